mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory port between the instruction-fetch requester (IMEM) and the load/store requester (DMEM). It sits between the CPU core's fetch and memory stages and a single-port synchronous memory with one-cycle read latency. It grants at most one access per cycle. DMEM has fixed priority, bounded by a starvation counter that guarantees fetch progress. It tags each read so the returning data is steered to the requester that issued it.

## Interface
Parameters:
- XLEN, 32, data/address width (from CPU_profile)
- STARVE_LIMIT, 4, consecutive denied IMEM-request cycles after which IMEM wins; legal range 1..15

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  input  1  fetch request, held until granted
- imem_addr  input  XLEN  fetch byte address
- imem_gnt  output  1  fetch accepted this cycle
- imem_rvalid  output  1  fetch data valid this cycle
- imem_rdata  output  XLEN  fetch data
- dmem_req  input  1  load/store request, held until granted
- dmem_we  input  1  1 = store, 0 = load
- dmem_wstrb  input  4  byte strobes for store
- dmem_addr  input  XLEN  load/store byte address
- dmem_wdata  input  XLEN  store data
- dmem_gnt  output  1  load/store accepted this cycle
- dmem_rvalid  output  1  load data valid this cycle (loads only)
- dmem_rdata  output  XLEN  load data
- mem_addr  output  XLEN  memory address
- mem_ren  output  1  memory read enable
- mem_wen  output  1  memory write enable
- mem_wstrb  output  4  memory byte strobes
- mem_wdata  output  XLEN  memory write data
- mem_rdata  input  XLEN  memory read data, valid one cycle after mem_ren

## Operation
- State: starve_cnt (4 bits), resp_tag register ∈ {NONE, IMEM, DMEM}.
- Grant logic is combinational and evaluated each cycle:
  - If only one requester asserts req, that requester is granted.
  - If both assert req and starve_cnt == STARVE_LIMIT, IMEM is granted; otherwise DMEM is granted.
  - If neither asserts req, no grant is issued.
- Memory command follows the grant in the same cycle:
  - IMEM grant: mem_addr=imem_addr, mem_ren=1, mem_wen=0, mem_wstrb=0, mem_wdata=0.
  - DMEM load: mem_addr=dmem_addr, mem_ren=1, mem_wen=0.
  - DMEM store: mem_addr=dmem_addr, mem_wen=1, mem_ren=0, mem_wstrb=dmem_wstrb, mem_wdata=dmem_wdata. A store with wstrb=0 is still granted and passed through.
  - No grant: all mem_* outputs are 0.
- starve_cnt update on each rising edge:
  - Cleared to 0 if imem_req=0 or imem_gnt=1.
  - Otherwise incremented, saturating at STARVE_LIMIT.
- resp_tag next value: IMEM if IMEM read was granted, DMEM if DMEM load was granted, NONE otherwise (including stores).
- Response steering:
  - imem_rvalid = (resp_tag==IMEM).
  - dmem_rvalid = (resp_tag==DMEM).
  - imem_rdata and dmem_rdata both = mem_rdata; they are meaningful only when the matching rvalid is asserted.
- Requesters must hold req and address/data stable until gnt. Deasserting req before gnt withdraws the request and causes no error.

## Timing
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req when arbitration is won.
- Read latency: rvalid is asserted exactly 1 cycle after gnt. Back-to-back reads give one response per cycle.
- Store takes 1 cycle and produces no response.
- Worst-case IMEM wait under continuous DMEM traffic is STARVE_LIMIT cycles. With STARVE_LIMIT=4, IMEM is granted on its 5th request cycle.
- A grant and an rvalid for a different requester may occur in the same cycle.
- Reset (asynchronous):
  - starve_cnt=0 and resp_tag=NONE.
  - imem_gnt, dmem_gnt, imem_rvalid, dmem_rvalid and all mem_* enables/strobes are 0 while rst=1.
  - A read granted in the cycle rst rises produces no rvalid.

## Test plan
- IMEM only: imem_req=1, imem_addr=0x40 → imem_gnt=1, mem_ren=1, mem_addr=0x40 the same cycle. The next cycle has imem_rvalid=1 and imem_rdata=mem_rdata; dmem_rvalid stays 0.
- Simultaneous requests: imem_req=dmem_req=1, dmem load at 0x100 → dmem_gnt=1, imem_gnt=0. The next cycle has dmem_rvalid=1; starve_cnt=1.
- Starvation bound: both req held with STARVE_LIMIT=4 → DMEM granted in cycles 0–3 and IMEM in cycle 4. starve_cnt returns to 0 and DMEM wins cycle 5.
- Store: dmem_we=1, wstrb=4'b0011, addr=0x200, wdata=0xDEADBEEF → mem_wen=1, mem_wstrb=4'b0011, mem_ren=0 the same cycle. No rvalid follows.
- Interleaved responses: IMEM read cycle 0, DMEM load cycle 1 → imem_rvalid in cycle 1, dmem_rvalid in cycle 2, and no cycle has both asserted.
- Reset mid-read: assert rst in the cycle after an IMEM grant → imem_rvalid=0 immediately, and all outputs remain 0 until a new request arrives after rst drops.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory (one-cycle read latency) between
// the instruction-fetch requester (IMEM) and the load/store requester (DMEM).
// DMEM has fixed priority, but a starvation counter forces an IMEM grant once
// IMEM has been denied STARVE_LIMIT consecutive cycles. Each granted read is
// tagged so the returning data is flagged valid for the requester that issued it.
//
// Ports:
//   clk, rst                    clock (rising edge) and async active-high reset
//   imem_req/addr               fetch request, held until imem_gnt
//   imem_gnt/rvalid/rdata       fetch accept, fetch response
//   dmem_req/we/wstrb/addr/wdata load/store request, held until dmem_gnt
//   dmem_gnt/rvalid/rdata       load/store accept, load response
//   mem_addr/ren/wen/wstrb/wdata memory command, driven in the grant cycle
//   mem_rdata                   memory read data, one cycle after mem_ren

module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_rvalid,
  output logic [XLEN-1:0] imem_rdata,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_gnt,
  output logic            dmem_rvalid,
  output logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_IMEM = 2'd1;
  localparam logic [1:0] TAG_DMEM = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [1:0] resp_tag;
  logic       grant_i;
  logic       grant_d;

  // Grants are suppressed while rst is high so nothing reaches the memory
  // during reset, even though the inputs may still be requesting.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (imem_req && dmem_req) begin
        if (starve_cnt == LIMIT) grant_i = 1'b1;
        else                     grant_d = 1'b1;
      end else if (imem_req) begin
        grant_i = 1'b1;
      end else if (dmem_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign imem_gnt = grant_i;
  assign dmem_gnt = grant_d;

  // Memory command; an ungranted cycle drives an all-zero command.
  always_comb begin
    mem_addr  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    if (grant_i) begin
      mem_addr = imem_addr;
      mem_ren  = 1'b1;
    end else if (grant_d) begin
      mem_addr = dmem_addr;
      if (dmem_we) begin
        mem_wen   = 1'b1;
        mem_wstrb = dmem_wstrb;
        mem_wdata = dmem_wdata;
      end else begin
        mem_ren = 1'b1;
      end
    end
  end

  // Counts consecutive cycles in which IMEM asked but lost; saturates at the
  // limit so the forced IMEM grant persists until it actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!imem_req || grant_i) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remembers who owns the data arriving next cycle; stores return nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_tag <= TAG_NONE;
    end else if (grant_i) begin
      resp_tag <= TAG_IMEM;
    end else if (grant_d && !dmem_we) begin
      resp_tag <= TAG_DMEM;
    end else begin
      resp_tag <= TAG_NONE;
    end
  end

  assign imem_rvalid = (resp_tag == TAG_IMEM);
  assign dmem_rvalid = (resp_tag == TAG_DMEM);
  assign imem_rdata  = mem_rdata;
  assign dmem_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter with directed request patterns, backs it with a simple
// synchronous memory whose read data is a function of the address, and
// checks grants/commands in the request cycle and responses one cycle later
// through a scoreboard of expected reads.

module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [3:0]      dmem_wstrb;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ren;
  logic            mem_wen;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  typedef struct {
    bit          is_imem;
    int          cyc;
    logic [31:0] data;
  } rsp_entry_t;

  rsp_entry_t sb[$];
  rsp_entry_t mon_e;
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_wstrb (dmem_wstrb),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .mem_addr   (mem_addr),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // Memory model: one-cycle read latency, data derived from the address.
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= memData(mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Drives one cycle of requests just after the clock edge and checks the
  // same-cycle grant and memory command; expected reads go to the scoreboard.
  task automatic applyStimulus(input string tag,
                               input bit ireq, input logic [31:0] iaddr,
                               input bit dreq, input bit dwe, input logic [3:0] dstrb,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input bit exp_ignt, input bit exp_dgnt);
    rsp_entry_t e;
    @(posedge clk);
    #1;
    imem_req   = ireq;
    imem_addr  = iaddr;
    dmem_req   = dreq;
    dmem_we    = dwe;
    dmem_wstrb = dstrb;
    dmem_addr  = daddr;
    dmem_wdata = dwdata;
    #3;
    checkOutput({tag, "_ignt"}, 32'(imem_gnt), 32'(exp_ignt));
    checkOutput({tag, "_dgnt"}, 32'(dmem_gnt), 32'(exp_dgnt));
    if (exp_ignt) begin
      checkOutput({tag, "_addr"},  mem_addr, iaddr);
      checkOutput({tag, "_ren"},   32'(mem_ren), 32'd1);
      checkOutput({tag, "_wen"},   32'(mem_wen), 32'd0);
      checkOutput({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
      e.is_imem = 1'b1;
      e.cyc     = cycle + 1;
      e.data    = memData(iaddr);
      sb.push_back(e);
    end else if (exp_dgnt) begin
      checkOutput({tag, "_addr"}, mem_addr, daddr);
      checkOutput({tag, "_ren"},  32'(mem_ren), 32'(!dwe));
      checkOutput({tag, "_wen"},  32'(mem_wen), 32'(dwe));
      if (dwe) begin
        checkOutput({tag, "_wstrb"}, 32'(mem_wstrb), 32'(dstrb));
        checkOutput({tag, "_wdata"}, mem_wdata, dwdata);
      end else begin
        e.is_imem = 1'b0;
        e.cyc     = cycle + 1;
        e.data    = memData(daddr);
        sb.push_back(e);
      end
    end else begin
      checkOutput({tag, "_ren"},   32'(mem_ren), 32'd0);
      checkOutput({tag, "_wen"},   32'(mem_wen), 32'd0);
      checkOutput({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
      checkOutput({tag, "_addr"},  mem_addr, 32'd0);
    end
  endtask

  task automatic idle();
    applyStimulus("idle", 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic checkAllQuiet(input string tag);
    checkOutput({tag, "_ignt"},   32'(imem_gnt), 32'd0);
    checkOutput({tag, "_dgnt"},   32'(dmem_gnt), 32'd0);
    checkOutput({tag, "_irv"},    32'(imem_rvalid), 32'd0);
    checkOutput({tag, "_drv"},    32'(dmem_rvalid), 32'd0);
    checkOutput({tag, "_ren"},    32'(mem_ren), 32'd0);
    checkOutput({tag, "_wen"},    32'(mem_wen), 32'd0);
    checkOutput({tag, "_wstrb"},  32'(mem_wstrb), 32'd0);
  endtask

  // Response monitor: every rvalid must match the oldest expected read, in
  // the right cycle, for the right requester, with the right data.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_rvalid || dmem_rvalid) begin
        checkOutput("rsp_both", 32'(imem_rvalid & dmem_rvalid), 32'd0);
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("rsp_owner", 32'(imem_rvalid), 32'(mon_e.is_imem));
          checkOutput("rsp_cycle", 32'(cycle), 32'(mon_e.cyc));
          checkOutput("rsp_data", imem_rvalid ? imem_rdata : dmem_rdata, mon_e.data);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cycle) begin
        checkOutput("rsp_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst        = 1'b1;
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_wstrb = 4'd0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    #2;
    checkAllQuiet("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lone fetch
    applyStimulus("imem_only", 1'b1, 32'h40, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle();

    // Both request: DMEM wins
    applyStimulus("both", 1'b1, 32'h44, 1'b1, 1'b0, 4'hF, 32'h100, 32'd0, 1'b0, 1'b1);
    idle();

    // Starvation bound: IMEM wins on its 5th request cycle, then DMEM again
    for (int i = 0; i < 6; i++)
      applyStimulus("starve", 1'b1, 32'h48, 1'b1, 1'b0, 4'd0, 32'h104 + 32'(i * 4), 32'd0,
                    i == 4, i != 4);
    idle();

    // Withdrawing IMEM clears the count, so the full wait starts over
    for (int i = 0; i < 3; i++)
      applyStimulus("pre_wd", 1'b1, 32'h4C, 1'b1, 1'b0, 4'd0, 32'h120, 32'd0, 1'b0, 1'b1);
    applyStimulus("withdraw", 1'b0, 32'h4C, 1'b1, 1'b0, 4'd0, 32'h124, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus("post_wd", 1'b1, 32'h50, 1'b1, 1'b0, 4'd0, 32'h128, 32'd0, i == 4, i != 4);
    idle();

    // Stores, including an all-zero strobe
    applyStimulus("store", 1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus("store0", 1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h204, 32'h12345678, 1'b0, 1'b1);
    idle();

    // Interleaved fetch then load
    applyStimulus("inter_i", 1'b1, 32'h60, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("inter_d", 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h300, 32'd0, 1'b0, 1'b1);
    idle();

    // Back-to-back fetches
    for (int i = 0; i < 3; i++)
      applyStimulus("b2b", 1'b1, 32'h70 + 32'(i * 4), 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle();

    // Reset arriving the cycle after a fetch grant cancels its response
    applyStimulus("pre_rst", 1'b1, 32'h80, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    dmem_req = 1'b1;
    sb.delete();
    #1;
    checkAllQuiet("rst_now");
    @(posedge clk);
    #3;
    checkAllQuiet("rst_hold");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    #3;
    checkAllQuiet("rst_rel");
    idle();
    #1;
    checkAllQuiet("rst_after");
    applyStimulus("post_rst", 1'b1, 32'h90, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle();
    idle();

    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
